// File: rtl/gf2m_mul_serial_pkg.sv
// Shared field constants and FSM state encoding for the digit-serial GF(2^M) multiplier
// and the blocks that reuse its digit step.
package gf2m_mul_serial_pkg;

  localparam int         SEED_GF_M    = 8;
  localparam logic [7:0] SEED_GF_POLY = 8'h63;
  localparam logic [1:0] GF4_POLY     = 2'b11;
  localparam logic [3:0] GF16_POLY    = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gf2m_digit_step.sv
// One digit step of MSB-first polynomial-basis multiplication:
// next_acc = acc * x^D mod P  ^  a * digit mod P.
module gf2m_digit_step
  import gf2m_mul_serial_pkg::*;
#(
  parameter int           M    = SEED_GF_M,
  parameter logic [M-1:0] POLY = SEED_GF_POLY,
  parameter int           D    = 1
) (
  input  logic [M-1:0] acc,
  input  logic [M-1:0] a,
  input  logic [D-1:0] digit,
  output logic [M-1:0] next_acc
);

  // Multiply by x and fold the overflowing x^M term back in as POLY.
  function automatic logic [M-1:0] mul_x(input logic [M-1:0] v);
    return (v << 1) ^ (v[M-1] ? POLY : '0);
  endfunction

  always_comb begin
    logic [M-1:0] shifted;
    logic [M-1:0] pp;
    logic [M-1:0] a_pow;
    shifted = acc;
    pp      = '0;
    a_pow   = a;
    for (int i = 0; i < D; i++) begin
      shifted = mul_x(shifted);
      if (digit[i]) pp = pp ^ a_pow;
      a_pow = mul_x(a_pow);
    end
    next_acc = shifted ^ pp;
  end

endmodule

// File: rtl/gf2m_mul_serial.sv
// Digit-serial GF(2^M) multiplier: consumes b MSB-first, D bits per cycle, with
// valid/ready handshakes on operand and product sides.
module gf2m_mul_serial
  import gf2m_mul_serial_pkg::*;
#(
  parameter int           M    = SEED_GF_M,
  parameter logic [M-1:0] POLY = SEED_GF_POLY,
  parameter int           D    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] p
);

  localparam int            D_SAFE   = (D < 1) ? 1 : D;
  localparam int            NDIG     = M / D_SAFE;
  localparam int            CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  generate
    if ((D < 1) || (D > M) || ((M % D_SAFE) != 0)) begin : g_bad_params
      $error("gf2m_mul_serial: D must be in 1..M and divide M");
    end
  endgenerate

  state_t        state;
  state_t        next_state;
  logic [M-1:0]  a_r;
  logic [M-1:0]  b_r;
  logic [M-1:0]  acc;
  logic [M-1:0]  step_acc;
  logic [CW-1:0] cnt;

  gf2m_digit_step #(
    .M   (M),
    .POLY(POLY),
    .D   (D_SAFE)
  ) u_step (
    .acc     (acc),
    .a       (a_r),
    .digit   (b_r[M-1 -: D_SAFE]),
    .next_acc(step_acc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (cnt == '0) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // p is gated so a partially accumulated value never reaches the output.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    p         = out_valid ? acc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
      acc <= '0;
      cnt <= CNT_LAST;
    end else if (state == RUN) begin
      acc <= step_acc;
      b_r <= b_r << D_SAFE;
      if (cnt != '0) cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_gf2m_mul_serial.sv
// Self-checking bench: three M=8 SEED-field instances (D=1,2,4) driven in lockstep
// plus one GF(4) instance, checked against hand values and a carry-less reference.
module tb_gf2m_mul_serial;
  import gf2m_mul_serial_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ir1, ov1, ir2, ov2, ir4, ov4;
  logic [7:0] p1, p2, p4;

  logic       m2_in_valid = 1'b0;
  logic       m2_out_ready = 1'b1;
  logic [1:0] m2_a = '0;
  logic [1:0] m2_b = '0;
  logic       m2_in_ready, m2_out_valid;
  logic [1:0] m2_p;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  gf2m_mul_serial #(.M(8), .POLY(8'h63), .D(1)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .p(p1));

  gf2m_mul_serial #(.M(8), .POLY(8'h63), .D(2)) dut_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a), .b(b),
    .out_valid(ov2), .out_ready(out_ready), .p(p2));

  gf2m_mul_serial #(.M(8), .POLY(8'h63), .D(4)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .a(a), .b(b),
    .out_valid(ov4), .out_ready(out_ready), .p(p4));

  gf2m_mul_serial #(.M(2), .POLY(2'b11), .D(1)) dut_m2 (
    .clk(clk), .rst(rst), .in_valid(m2_in_valid), .in_ready(m2_in_ready), .a(m2_a),
    .b(m2_b), .out_valid(m2_out_valid), .out_ready(m2_out_ready), .p(m2_p));

  // Full carry-less product first, then reduce from the top bit down.
  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                         input int m, input logic [7:0] poly);
    logic [15:0] prod;
    prod = '0;
    for (int i = 0; i < m; i++)
      if (y[i]) prod = prod ^ (16'(x) << i);
    for (int i = 2 * m - 2; i >= m; i--)
      if (prod[i]) prod = prod ^ (16'(poly) << (i - m)) ^ (16'd1 << i);
    return prod[7:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One operation on all three M=8 instances; records when and what each presents.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] exp);
    int lat1, lat2, lat4;
    logic [7:0] s1, s2, s4;
    lat1 = -1; lat2 = -1; lat4 = -1;
    s1 = '0; s2 = '0; s4 = '0;
    checkOutput("ready_before_op", {29'd0, ir1, ir2, ir4}, 32'h7);
    a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~av; b = ~bv;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ov1 && lat1 < 0) begin lat1 = k; s1 = p1; end
      if (ov2 && lat2 < 0) begin lat2 = k; s2 = p2; end
      if (ov4 && lat4 < 0) begin lat4 = k; s4 = p4; end
    end
    checkOutput("p_d1", 32'(s1), 32'(exp));
    checkOutput("p_d2", 32'(s2), 32'(exp));
    checkOutput("p_d4", 32'(s4), 32'(exp));
    checkOutput("latency_d1", 32'(lat1), 32'd8);
    checkOutput("latency_d2", 32'(lat2), 32'd4);
    checkOutput("latency_d4", 32'(lat4), 32'd2);
  endtask

  task automatic applyStimulusM2(input logic [1:0] av, input logic [1:0] bv, input logic [1:0] exp);
    int lat;
    logic [1:0] s;
    lat = -1; s = '0;
    checkOutput("m2_ready", 32'(m2_in_ready), 32'd1);
    m2_a = av; m2_b = bv; m2_in_valid = 1'b1; m2_out_ready = 1'b1;
    @(posedge clk); #1;
    m2_in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (m2_out_valid && lat < 0) begin lat = k; s = m2_p; end
    end
    checkOutput("m2_p", 32'(s), 32'(exp));
    checkOutput("m2_latency", 32'(lat), 32'd2);
  endtask

  initial begin
    vecs[0] = '{8'h02, 8'h80, 8'h63};
    vecs[1] = '{8'h03, 8'h03, 8'h05};
    vecs[2] = '{8'h01, 8'hA7, 8'hA7};
    vecs[3] = '{8'h00, 8'hFF, 8'h00};
    vecs[4] = '{8'hFF, 8'h00, 8'h00};
    vecs[5] = '{8'h02, 8'h02, 8'h04};
    vecs[6] = '{8'h80, 8'h02, 8'h63};

    #1;
    checkOutput("reset_in_ready", 32'(ir1), 32'd1);
    checkOutput("reset_out_valid", 32'(ov1), 32'd0);
    checkOutput("reset_p", 32'(p1), 32'd0);
    checkOutput("reset_m2_p", 32'(m2_p), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 7; i++)
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].p);

    applyStimulusM2(2'b10, 2'b10, 2'b11);
    for (int i = 0; i < 16; i++)
      applyStimulusM2(2'(i >> 2), 2'(i), 2'(ref_mul(8'(i >> 2), 8'(i & 3), 2, 8'h03)));

    // Backpressure: hold the product for 5 cycles while in_valid pulses are ignored.
    a = 8'h03; b = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'hFF; b = 8'hFF;
    for (int k = 0; k < 20; k++) begin
      if (ov1) break;
      @(posedge clk); #1;
    end
    checkOutput("bp_reached_done", 32'(ov1), 32'd1);
    for (int j = 0; j < 5; j++) begin
      in_valid = (j % 2 == 0);
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(ov1), 32'd1);
      checkOutput("bp_p_stable", 32'(p1), 32'h05);
      checkOutput("bp_in_ready", 32'(ir1), 32'd0);
      checkOutput("bp_p_d4_stable", 32'(p4), 32'h05);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_valid", 32'(ov1), 32'd0);
    checkOutput("bp_release_ready", 32'(ir1), 32'd1);

    // Reset in the 3rd RUN cycle of D=1 while the D=4 instance is parked in DONE.
    a = 8'h57; b = 8'h83; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("pre_reset_d4_done", 32'(ov4), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(ov1), 32'd0);
    checkOutput("abort_p", 32'(p1), 32'd0);
    checkOutput("abort_in_ready", 32'(ir1), 32'd1);
    checkOutput("abort_d4_out_valid", 32'(ov4), 32'd0);
    checkOutput("abort_d4_p", 32'(p4), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    applyStimulus(8'h57, 8'h83, ref_mul(8'h57, 8'h83, 8, 8'h63));

    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, ref_mul(ra, rb, 8, 8'h63));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
